// File: rtl/kf_cov_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kf_cov_arbiter
// Brief    : Two-requester arbiter in front of a shared covariance-prediction
//            engine (S = A*P*A^T + Q). Grants one operand set at a time,
//            issues a single-cycle start to the engine, waits for completion
//            with a timeout, and returns the result over a valid/ready port.
//            The operand and result words are forwarded without arithmetic.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N        data word width (signed fixed point), one matrix element
//   FRAC     fractional bits of the data words (informational only)
//   TIMEOUT  maximum number of WAIT cycles without eng_done before abort
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_* / req1_*                 requester operand sets, valid/ready
//                                   a/p/q packed {x11,x10,x01,x00}
//   eng_start                       one-cycle engine start
//   eng_a, eng_p, eng_q             registered operands to the engine
//   eng_done, eng_s                 engine completion pulse and result
//   rsp_valid, rsp_ready            result handshake
//   rsp_id, rsp_s                   owning requester and captured result
//   err_timeout                     one-cycle pulse on engine timeout
//   busy                            high whenever the FSM is not IDLE
// ============================================================================
module kf_cov_arbiter #(
    parameter int N       = 20,
    parameter int FRAC    = 10,
    parameter int TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [4*N-1:0] req0_a,
    input  logic [4*N-1:0] req0_p,
    input  logic [4*N-1:0] req0_q,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [4*N-1:0] req1_a,
    input  logic [4*N-1:0] req1_p,
    input  logic [4*N-1:0] req1_q,

    output logic           eng_start,
    output logic [4*N-1:0] eng_a,
    output logic [4*N-1:0] eng_p,
    output logic [4*N-1:0] eng_q,
    input  logic           eng_done,
    input  logic [4*N-1:0] eng_s,

    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [4*N-1:0] rsp_s,

    output logic           err_timeout,
    output logic           busy
);

    // ------------------------------------------------------------------------
    // Elaboration-time sanity check on the configuration.
    // ------------------------------------------------------------------------
    generate
        if (TIMEOUT < 1 || FRAC < 0 || FRAC >= N) begin : g_bad_params
            $error("kf_cov_arbiter: requires TIMEOUT >= 1 and 0 <= FRAC < N");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    // The counter starts at 0 on WAIT entry and the abort is taken on the
    // TIMEOUT-th WAIT cycle that passes without eng_done.
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_last_id;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err_timeout;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic w_grant_valid;
    logic w_grant_id;
    logic w_accept;
    logic w_done_in_wait;
    logic w_timeout;
    logic w_release;

    // Grant selection. On a tie the requester that was NOT served last wins,
    // giving strict alternation under sustained contention.
    always_comb begin
        w_grant_valid = req0_valid | req1_valid;
        w_grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_id;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
    end

    // eng_done is only meaningful in WAIT; everywhere else it is ignored.
    assign w_accept       = (r_state == S_IDLE) && w_grant_valid;
    assign w_done_in_wait = (r_state == S_WAIT) && eng_done;
    assign w_timeout      = (r_state == S_WAIT) && !eng_done && (r_cnt == c_CNT_LAST);
    assign w_release      = (r_state == S_RESP) && rsp_ready;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_in_wait) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                // Releasing returns to IDLE; a new request can only be taken
                // from IDLE, so there is always one cycle between a release
                // and the next acceptance.
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    // The ready terms are gated by rst_n so that nothing is offered while
    // reset is asserted, even though IDLE is forced asynchronously.
    always_comb begin
        eng_start  = (r_state == S_ISSUE);
        busy       = (r_state != S_IDLE);
        rsp_valid  = (r_state == S_RESP);
        req0_ready = rst_n && w_accept && !w_grant_id;
        req1_ready = rst_n && w_accept &&  w_grant_id;
    end

    // ------------------------------------------------------------------------
    // Datapath and bookkeeping registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_a         <= '0;
            eng_p         <= '0;
            eng_q         <= '0;
            rsp_id        <= 1'b0;
            rsp_s         <= '0;
            r_last_id     <= 1'b1;
            r_cnt         <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            // Operands are captured only at acceptance and therefore hold
            // steady through ISSUE and WAIT.
            if (w_accept) begin
                eng_a  <= w_grant_id ? req1_a : req0_a;
                eng_p  <= w_grant_id ? req1_p : req0_p;
                eng_q  <= w_grant_id ? req1_q : req0_q;
                rsp_id <= w_grant_id;
            end

            if (r_state == S_ISSUE || w_timeout) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !eng_done) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_done_in_wait) begin
                rsp_s <= eng_s;
            end

            // Both completion paths (normal release and abort) count as
            // having served rsp_id for the purpose of tie-breaking.
            if (w_timeout || w_release) begin
                r_last_id <= rsp_id;
            end

            r_err_timeout <= w_timeout;
        end
    end

    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: doc/kf_cov_arbiter.md
KF_COV_ARBITER -- requirements
Module: kf_cov_arbiter

Interface
REQ-001 SHALL have parameter N, default 20: data word width, signed fixed point.
REQ-002 SHALL have parameter FRAC, default 10: fractional bits; passed through unchanged.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before abort.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 reqK_valid  in  1  (K=0,1) requester K has an operand set.
REQ-007 reqK_ready  out  1  (K=0,1) request K accepted this cycle.
REQ-008 reqK_a, reqK_p, reqK_q  in  4N each  (K=0,1) packed {x11,x10,x01,x00}.
REQ-009 eng_start  out  1  single-cycle start to the shared S=A*P*A^T+Q engine.
REQ-010 eng_a, eng_p, eng_q  out  4N each  registered operands to the engine, same packing.
REQ-011 eng_done  in  1  engine completion pulse.
REQ-012 eng_s  in  4N  engine result {P_PRIOR11,P_PRIOR10,P_PRIOR01,P_PRIOR00}.
REQ-013 rsp_valid  out  1  result available.
REQ-014 rsp_ready  in  1  consumer accepts result.
REQ-015 rsp_id  out  1  requester index that owns rsp_s.
REQ-016 rsp_s  out  4N  captured result.
REQ-017 err_timeout  out  1  one-cycle pulse on engine timeout.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE, grant: if only one reqK_valid is high, grant K; if both are high, grant the index not equal to last_id.
REQ-021 reqK_ready SHALL be combinational: high only in IDLE, only for the granted K, only while reqK_valid is high; never for both.
REQ-022 On a handshake edge: latch reqK_a/p/q into eng_a/p/q, latch K into rsp_id, go to ISSUE.
REQ-023 ISSUE: eng_start=1 for exactly this one cycle; clear wait counter; go to WAIT.
REQ-024 WAIT: if eng_done=1, capture eng_s into rsp_s, set rsp_valid=1, go to RESP; otherwise increment the counter.
REQ-025 WAIT: if the counter reaches TIMEOUT with eng_done low, pulse err_timeout for one cycle, set last_id=rsp_id, go to IDLE, and do not assert rsp_valid.
REQ-026 eng_done and eng_s SHALL be ignored in IDLE, ISSUE and RESP.
REQ-027 RESP: hold rsp_valid, rsp_id and rsp_s stable until rsp_ready=1. On that edge: clear rsp_valid, set last_id=rsp_id, go to IDLE.
REQ-028 Latency with the 8-cycle engine: with the handshake on edge E, eng_start is high between E and E+1, and rsp_valid rises at edge E+9.
REQ-029 A new request SHALL NOT be accepted in the same cycle as the RESP release; the earliest acceptance is the next IDLE cycle.
REQ-030 eng_a/p/q SHALL remain constant from ISSUE through WAIT.
REQ-031 No arithmetic SHALL be applied to the data; widths are passed through bit-exact.

Reset
REQ-032 Reset asserted in any state SHALL force state=IDLE, last_id=1 (so req0 wins the first tie), counter=0, and all outputs 0: eng_start, eng_a/p/q, rsp_valid, rsp_id, rsp_s, err_timeout, busy, reqK_ready.
REQ-033 An engine result pending at reset SHALL be discarded; an eng_done arriving after reset SHALL be ignored.

Verification
REQ-034 Single req0, A=I (0x400 diagonal), P=diag(0x400,0x800), Q=0 -> req0_ready for one cycle, eng_start one cycle later, rsp_valid at E+9 with rsp_id=0 and rsp_s={0x800,0,0,0x400}.
REQ-035 req0 and req1 held valid for 4 transactions, rsp_ready=1 -> grant order 0,1,0,1; rsp_id matches each time.
REQ-036 eng_done tied low -> err_timeout pulses TIMEOUT cycles after WAIT entry; FSM returns to IDLE; rsp_valid never rises; the next tie grants the other requester.
REQ-037 rsp_ready held low 5 cycles after rsp_valid -> rsp_s and rsp_id stable; both reqK_ready stay low; busy=1 throughout.
REQ-038 rst_n pulsed low during WAIT, with a late eng_done after release -> all outputs 0 and rsp_valid stays 0; the next tie grants req0.
REQ-039 Spurious eng_done while in IDLE -> no change to rsp_valid or rsp_s.
